// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer and the control unit that decodes op.
// The pc-select codes here must match the control unit's `pc` output encoding.
// The STALL state exists only when FETCH_SEQ_STEP_EN is defined.
package fetch_seq_pkg;

  // Next-PC select codes driven by the control unit.
  localparam logic [2:0] cu_pc_inc  = 3'b000;
  localparam logic [2:0] cu_pc_jmp  = 3'b001;
  localparam logic [2:0] cu_pc_hold = 3'b010;

`ifdef FETCH_SEQ_STEP_EN
  typedef enum logic [2:0] {
    st_fetch = 3'd0,
    st_wait  = 3'd1,
    st_exec  = 3'd2,
    st_halt  = 3'd3,
    st_stall = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    st_fetch = 3'd0,
    st_wait  = 3'd1,
    st_exec  = 3'd2,
    st_halt  = 3'd3
  } state_t;
`endif

  // True when the select code stops the sequencer.
  function automatic logic is_hold(input logic [2:0] sel);
    return sel == cu_pc_hold;
  endfunction

endpackage

// File: rtl/fetch_seq_pc_next.sv
// Next-PC calculation: increment with natural wrap, jump to the op address
// field, or hold. Unknown select codes fall back to increment.
module fetch_seq_pc_next
  import fetch_seq_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] pc,
  input  logic [2:0]    pc_sel,
  input  logic [AW-1:0] jmp_addr,
  output logic [AW-1:0] pc_nxt,
  output logic          hold
);

  // Select next PC; the AW-bit add wraps the top address back to 0.
  always_comb begin
    pc_nxt = pc + AW'(1);
    hold   = is_hold(pc_sel);
    if (pc_sel == cu_pc_jmp) begin
      pc_nxt = jmp_addr;
    end else if (hold) begin
      pc_nxt = pc;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch/sequencer for the 8-bit accumulator CPU.
// Sequence per instruction: FETCH (request) -> WAIT (capture) -> EXEC (op_valid).
// Macro FETCH_SEQ_STEP_EN adds a `step` input and a STALL state after each EXEC.
//
// Memory handshake: imem_req is a single-cycle strobe with imem_addr valid in
// the same cycle; the response is accepted only while in WAIT on the first
// cycle imem_valid=1. imem_valid in any other state is discarded.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_valid,
  output logic [DW-1:0] op,
  output logic          op_valid,
  input  logic [2:0]    pc_sel,
`ifdef FETCH_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] pc_out,
  output logic          halted,
  output state_t        state_dbg
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_nxt;
  logic          pc_hold;
  logic          capture;
  logic          pc_load;

  fetch_seq_pc_next #(.AW(AW)) u_pc_next (
    .pc       (pc),
    .pc_sel   (pc_sel),
    .jmp_addr (op[AW-1:0]),
    .pc_nxt   (pc_nxt),
    .hold     (pc_hold)
  );

  // Next-state and register-load decisions.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    pc_load   = 1'b0;
    case (state)
      st_fetch: state_nxt = st_wait;
      st_wait: begin
        if (imem_valid) begin
          capture   = 1'b1;
          state_nxt = st_exec;
        end
      end
      st_exec: begin
        if (pc_hold) begin
          state_nxt = st_halt;
        end else begin
          pc_load = 1'b1;
`ifdef FETCH_SEQ_STEP_EN
          state_nxt = st_stall;
`else
          state_nxt = st_fetch;
`endif
        end
      end
      st_halt: state_nxt = st_halt;
`ifdef FETCH_SEQ_STEP_EN
      st_stall: begin
        if (step) begin
          state_nxt = st_fetch;
        end
      end
`endif
      default: state_nxt = st_fetch;
    endcase
  end

  // State, PC and instruction register; reset is the only way out of HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_fetch;
      pc    <= AW'(RESET_PC);
      op    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        op <= imem_rdata;
      end
      if (pc_load) begin
        pc <= pc_nxt;
      end
    end
  end

  // Strobes are forced low while reset is asserted.
  always_comb begin
    imem_req  = !rst && (state == st_fetch);
    imem_addr = imem_req ? pc : '0;
    op_valid  = !rst && (state == st_exec);
    halted    = !rst && (state == st_halt);
    pc_out    = pc;
    state_dbg = state;
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed programs in a bench memory,
// an event-level reference model checked every cycle, plus literal pins.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [4:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic [7:0] op;
  logic       op_valid;
  logic [2:0] pc_sel;
  logic [4:0] pc_out;
  logic       halted;
  state_t     state_dbg;
`ifdef FETCH_SEQ_STEP_EN
  logic       step;
`endif

  fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .op         (op),
    .op_valid   (op_valid),
    .pc_sel     (pc_sel),
`ifdef FETCH_SEQ_STEP_EN
    .step       (step),
`endif
    .pc_out     (pc_out),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- bench memory and control-unit stand-in ----------------
  logic [7:0] imem[32];
  logic [2:0] sel_mem[32];
  int         lat;
  bit         stray_en;

  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Program A: adds everywhere, jump 3->22, jump 22->30, odd select code at 2.
  task automatic load_prog_a();
    for (int i = 0; i < 32; i++) begin
      imem[i]    = 8'h41;
      sel_mem[i] = cu_pc_inc;
    end
    for (int i = 0; i < 3; i++) imem[i] = 8'h43;
    sel_mem[2]  = 3'b111;
    imem[3]     = 8'h96;
    sel_mem[3]  = cu_pc_jmp;
    imem[22]    = 8'h9E;
    sel_mem[22] = cu_pc_jmp;
  endtask

  // Program B: one add then a stop instruction held at address 1.
  task automatic load_prog_b();
    for (int i = 0; i < 32; i++) begin
      imem[i]    = 8'h41;
      sel_mem[i] = cu_pc_inc;
    end
    imem[1]    = 8'hE0;
    sel_mem[1] = cu_pc_hold;
  endtask

  // Memory responder: answers each request after `lat` cycles; optionally
  // injects a stray valid in the cycle after an EXEC or while halted.
  initial begin : responder
    bit         pend;
    bit         stray;
    int         remain;
    logic [4:0] raddr;
    pend       = 1'b0;
    stray      = 1'b0;
    remain     = 0;
    raddr      = '0;
    imem_valid = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend  = 1'b0;
        stray = 1'b0;
      end else begin
        if (imem_req) begin
          pend   = 1'b1;
          remain = lat;
          raddr  = imem_addr;
        end
        if ((op_valid || halted) && stray_en) stray = 1'b1;
      end
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_rdata = 8'hEE;
      if (pend) begin
        remain--;
        if (remain == 0) begin
          imem_valid = 1'b1;
          imem_rdata = imem[raddr];
          pend       = 1'b0;
        end
      end else if (stray) begin
        imem_valid = 1'b1;
        imem_rdata = 8'hE5;
        stray      = 1'b0;
      end
    end
  end

  // Control-unit stand-in: select code depends on the executing address.
  initial begin : sel_driver
    pc_sel = cu_pc_inc;
    forever begin
      @(posedge clk);
      #1 pc_sel = sel_mem[pc_out];
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0] exp_q[$];
  int         flog[$];
  int         rlog[$];
  int         ovlog[$];
  int         cyc;

  initial begin : compare
    int         m_pc;
    bit         m_halt;
    bit         halt_next;
    bit         req_due;
    bit         ov_due;
    bit         awaiting;
    bit         m_stalled;
    bit         req_now;
    bit         ov_now;
    logic [7:0] e;
    m_pc = 0; m_halt = 0; halt_next = 0; req_due = 0; ov_due = 0;
    awaiting = 0; m_stalled = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_halted", 32'(halted), 0);
        m_pc = 0; m_halt = 0; halt_next = 0; req_due = 1; ov_due = 0;
        awaiting = 0; m_stalled = 0; cyc = 0;
        exp_q.delete(); flog.delete(); rlog.delete(); ovlog.delete();
      end else begin
        cyc++;
        req_now = req_due && !m_halt;
        req_due = 0;
        ov_now  = ov_due;
        ov_due  = 0;
        check("imem_req", 32'(imem_req), 32'(req_now));
        if (req_now) begin
          check("imem_addr", 32'(imem_addr), 32'(m_pc));
          exp_q.push_back(imem[m_pc]);
        end
        if (imem_req) begin
          flog.push_back(int'(imem_addr));
          rlog.push_back(cyc);
        end
        check("op_valid", 32'(op_valid), 32'(ov_now));
        if (op_valid) ovlog.push_back(cyc);
        check("halted", 32'(halted), 32'(m_halt));
        check("pc_out", 32'(pc_out), 32'(m_pc));
        if (awaiting && imem_valid) begin
          ov_due   = 1;
          awaiting = 0;
        end
        if (req_now) awaiting = 1;
`ifdef FETCH_SEQ_STEP_EN
        if (m_stalled && step) begin
          m_stalled = 0;
          req_due   = 1;
        end
`endif
        if (ov_now) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL op_queue: got op 0x%0h, expected none pending", op);
          end else begin
            e = exp_q.pop_front();
            check("op", 32'(op), 32'(e));
            if (pc_sel == cu_pc_hold) begin
              halt_next = 1;
            end else begin
              if (pc_sel == cu_pc_jmp) m_pc = int'(e[4:0]);
              else m_pc = (m_pc + 1) % 32;
`ifdef FETCH_SEQ_STEP_EN
              m_stalled = 1;
`else
              req_due = 1;
`endif
            end
          end
        end
        if (halt_next) begin
          m_halt    = 1;
          halt_next = 0;
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin : main
    rst      = 1'b1;
    lat      = 1;
    stray_en = 1'b0;
    n_checks = 0;
    n_errors = 0;
`ifdef FETCH_SEQ_STEP_EN
    step = 1'b0;
`endif

`ifndef FETCH_SEQ_STEP_EN
    // Sequential fetch, jumps, odd select code and 31 -> 0 wrap.
    load_prog_a();
    do_reset();
    @(negedge clk);
    check("reset_op", 32'(op), 0);
    check("reset_pc_out", 32'(pc_out), 0);
    repeat (25) @(posedge clk);
    check("req_cycle_0", 32'(rlog[0]), 1);
    check("req_cycle_1", 32'(rlog[1]), 4);
    check("req_cycle_2", 32'(rlog[2]), 7);
    check("first_op_valid_cycle", 32'(ovlog[0]), 3);
    check("fetch_addr_0", 32'(flog[0]), 0);
    check("fetch_addr_1", 32'(flog[1]), 1);
    check("fetch_addr_2", 32'(flog[2]), 2);
    check("fetch_addr_after_odd_sel", 32'(flog[3]), 3);
    check("fetch_addr_after_jmp", 32'(flog[4]), 22);
    check("fetch_addr_30", 32'(flog[5]), 30);
    check("fetch_addr_31", 32'(flog[6]), 31);
    check("fetch_addr_wrap", 32'(flog[7]), 0);

    // 4-cycle latency with a stray valid in the FETCH cycle.
    lat      = 4;
    stray_en = 1'b1;
    do_reset();
    repeat (20) @(posedge clk);
    check("lat4_req_cycle_0", 32'(rlog[0]), 1);
    check("lat4_op_valid_cycle_0", 32'(ovlog[0]), 6);
    check("lat4_req_cycle_1", 32'(rlog[1]), 7);
    check("lat4_op_valid_cycle_1", 32'(ovlog[1]), 12);
    check("lat4_op_valid_count", 32'(ovlog.size()), 3);

    // Halt on HOLD, stray valids while halted, then reset restarts fetching.
    load_prog_b();
    lat = 1;
    do_reset();
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("halt_req_count", 32'(rlog.size()), 2);
    check("halt_halted", 32'(halted), 1);
    check("halt_pc_out", 32'(pc_out), 1);
    check("halt_op_kept", 32'(op), 32'h0000_00E0);
    check("halt_op_valid_count", 32'(ovlog.size()), 2);
    stray_en = 1'b0;
    do_reset();
    @(negedge clk);
    check("post_halt_pc_out", 32'(pc_out), 0);
    check("post_halt_halted", 32'(halted), 0);
    check("post_halt_req", 32'(imem_req), 1);
`else
    // Single-step: step in the EXEC cycle is ignored; one pulse runs one more.
    load_prog_a();
    lat = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc == 2) break;
    end
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (15) @(posedge clk);
    check("step_first_exec_cycle", 32'(ovlog[0]), 3);
    check("step_op_valid_count_0", 32'(ovlog.size()), 1);
    check("step_req_count_0", 32'(rlog.size()), 1);
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (15) @(posedge clk);
    check("step_op_valid_count_1", 32'(ovlog.size()), 2);
    check("step_req_count_1", 32'(rlog.size()), 2);
    check("step_second_addr", 32'(flog[1]), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction fetch/sequencer for the 8-bit accumulator CPU.
- Owns the program counter and fetches instructions from instruction memory.
- Presents each instruction on `op` to the control unit for one execute cycle.
- Consumes the control unit's resolved 3-bit `pc` select to form the next PC.
- It is the producer side of the `op`/`pc` interface that the control unit decodes.

Parameters:
- AW, 5, instruction address width; equals the op[4:0] address field.
- DW, 8, instruction width; op[7:5] opcode, op[4:0] operand/sub-op.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  one-cycle fetch request.
- imem_addr  output  AW  fetch address; valid while imem_req=1.
- imem_rdata  input  DW  returned instruction.
- imem_valid  input  1  imem_rdata valid this cycle.
- op  output  DW  instruction register to the control unit.
- op_valid  output  1  execute strobe; the control unit's wmem/wacc are qualified by it.
- pc_sel  input  3  next-PC select from the control unit (its `pc` output).
- pc_out  output  AW  current PC, for debug.
- halted  output  1  sequencer stopped.

Behaviour:
- Reset values: imem_req=0, imem_addr=0, op=0, op_valid=0, pc_out=RESET_PC, halted=0; state=FETCH.
- Reset is synchronous and active-high; it is the only exit from HALT.
- State FETCH:
  - Drive imem_req=1 and imem_addr=pc for exactly one cycle, then go to WAIT.
  - imem_valid seen in FETCH is ignored.
- State WAIT:
  - Hold imem_req=0.
  - On imem_valid=1: op<=imem_rdata, go to EXEC.
  - No timeout; WAIT is held indefinitely.
  - Minimum fetch latency is 1 cycle, giving 3 cycles per instruction.
- State EXEC:
  - op_valid=1 for exactly one cycle; pc_sel is sampled this cycle.
  - PC_INC (3'b000): pc<=pc+1, wrapping modulo 2^AW (31 -> 0).
  - PC_JMP (3'b001): pc<=op[4:0]. A taken conditional branch is resolved by the control unit and arrives as PC_JMP.
  - PC_HOLD (3'b010): pc unchanged; go to HALT and set halted=1 from the next cycle.
  - Any other code: treated as PC_INC.
  - After PC_INC or PC_JMP: go to FETCH.
- State HALT:
  - op_valid=0 and imem_req=0; op retains the stop instruction.
  - imem_valid is ignored.
- op is stable from entry to EXEC until the next WAIT capture.
- Reset during WAIT: the instruction memory shares rst and drops any outstanding response; the sequencer refetches from RESET_PC.
- imem_valid while not in WAIT is always discarded.

Optional Feature:
- Macro: FETCH_SEQ_STEP_EN.
- Defined:
  - Adds input `step` (1 bit) and state STALL, entered after every EXEC that does not halt.
  - STALL leaves to FETCH on step=1.
  - A step pulse present in the EXEC cycle itself is not counted.
- Undefined:
  - No `step` port and no STALL state; EXEC goes directly to FETCH.

Decomposition:
- Shared defines header cu_defs.vh, alongside the existing control-unit opcode defines, holds:
  - pc-select codes `cu_pc_inc`, `cu_pc_jmp`, `cu_pc_hold`;
  - state encodings.
- The control unit and this block must both include it so the `pc` codes agree.
- One natural sub-module: pc_next, a combinational block computing next PC from pc, pc_sel and op[4:0], including the wrap rule.

Test Plan:
- Reset, then memory returns {add,00011} with 1-cycle latency and pc_sel=INC -> imem_req at cycles 1,4,7; op_valid at cycle 3; imem_addr sequence 0,1,2.
- EXEC of {jmp,10110} with pc_sel=JMP -> next imem_addr=22; pc_out=22.
- pc=31 with pc_sel=INC -> next imem_addr=0.
- Fetch latency of 4 cycles with imem_valid pulsed during FETCH -> FETCH pulse ignored; capture occurs on the WAIT cycle; op_valid once.
- {long_begin,stop} with pc_sel=HOLD -> halted=1 the next cycle; no further imem_req over 20 cycles; pc_out unchanged; rst -> pc_out=0 and fetching resumes.
- FETCH_SEQ_STEP_EN defined, step held 0 -> exactly one op_valid, then STALL; one step pulse -> exactly one more instruction executes.
